// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types for the CNN activation stage: activation mode
//               encoding and the frame-sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  typedef enum logic [1:0] {
    MODE_RELU   = 2'd0,
    MODE_LEAKY  = 2'd1,
    MODE_RELU6  = 2'd2,
    MODE_BYPASS = 2'd3
  } act_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/act_lane.sv
`default_nettype none
// ============================================================================
// Module      : act_lane
// Description : Combinational per-element activation function.
//   v       : signed input element
//   mode    : selected activation
//   y       : activated element
//   is_neg  : input element is negative (any mode)
//   is_clip : input exceeds CLIP_MAX while in RELU6 mode
// Revision    : 1.0 - initial release
// ============================================================================
module act_lane
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_MAX   = 768
) (
  input  logic signed [DATA_WIDTH-1:0] v,
  input  act_mode_t                    mode,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         is_neg,
  output logic                         is_clip
);

  localparam logic signed [DATA_WIDTH-1:0] CLIP = DATA_WIDTH'(CLIP_MAX);

  logic over;

  assign is_neg  = v[DATA_WIDTH-1];
  assign over    = (v > CLIP);
  assign is_clip = (mode == MODE_RELU6) && over;

  always_comb begin
    y = v;
    case (mode)
      MODE_RELU:   y = is_neg ? '0 : v;
      // Arithmetic shift floors toward -inf, e.g. -9 -> -2 for a shift of 3.
      MODE_LEAKY:  y = is_neg ? (v >>> LEAK_SHIFT) : v;
      MODE_RELU6:  y = is_neg ? '0 : (over ? CLIP : v);
      default:     y = v;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/activation_unit.sv
`default_nettype none
// ============================================================================
// Module      : activation_unit
// Description : Applies a run-time selected activation (ReLU, leaky ReLU,
//               ReLU6, bypass) to a whole CHANNELS x IMG_SIZE x IMG_SIZE map,
//               LANES elements per cycle, with start/done frame handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   start, mode  : frame request and activation, sampled in IDLE only
//   in_feature   : source map, held stable while busy
//   out_feature  : result map (storage, not reset)
//   busy, done   : frame in progress / one-cycle completion pulse
//   neg_count    : negative input elements in the last frame (saturating)
//   clip_count   : elements clamped in RELU6 in the last frame (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module activation_unit
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 7,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_MAX   = 6 << FRAC_BITS,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic signed [DATA_WIDTH-1:0] in_feature  [CHANNELS][IMG_SIZE][IMG_SIZE],
  output logic signed [DATA_WIDTH-1:0] out_feature [CHANNELS][IMG_SIZE][IMG_SIZE],
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         neg_count,
  output logic [CNT_WIDTH-1:0]         clip_count
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int QW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int LW = $clog2(LANES + 1);

  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [QW-1:0] R_LAST = QW'(IMG_SIZE - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(IMG_SIZE - LANES);
  localparam logic [QW-1:0] Q_STEP = QW'(LANES);

  if ((IMG_SIZE % LANES) != 0) begin : g_lane_check
    $error("activation_unit: IMG_SIZE must be a multiple of LANES");
  end
  if ((CLIP_MAX <= 0) || (CLIP_MAX > (2 ** (DATA_WIDTH - 1)) - 1)) begin : g_clip_check
    $error("activation_unit: CLIP_MAX must be positive and fit DATA_WIDTH");
  end

  state_t    state, state_next;
  logic      busy_next, done_next, accept, last_beat;
  act_mode_t mode_q;

  logic [CW-1:0] c;
  logic [QW-1:0] r, q;

  // Read-stage register: one beat of raw input plus where it came from.
  logic                         pipe_valid;
  logic signed [DATA_WIDTH-1:0] pipe_data [LANES];
  logic [CW-1:0]                pipe_c;
  logic [QW-1:0]                pipe_r, pipe_q;

  logic signed [DATA_WIDTH-1:0] lane_y    [LANES];
  logic [LANES-1:0]             lane_neg, lane_clip;
  logic [LW-1:0]                neg_inc, clip_inc;
  logic [CNT_WIDTH:0]           neg_sum, clip_sum;

  assign last_beat = (c == C_LAST) && (r == R_LAST) && (q == Q_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_next  = busy;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          busy_next  = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN:    if (last_beat) state_next = ST_DRAIN;
      ST_DRAIN:  state_next = ST_FINISH;
      ST_FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- lanes
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .CLIP_MAX   (CLIP_MAX)
    ) u_act_lane (
      .v       (pipe_data[l]),
      .mode    (mode_q),
      .y       (lane_y[l]),
      .is_neg  (lane_neg[l]),
      .is_clip (lane_clip[l])
    );
  end

  always_comb begin
    neg_inc  = '0;
    clip_inc = '0;
    for (int l = 0; l < LANES; l++) begin
      neg_inc  = neg_inc  + LW'(lane_neg[l]);
      clip_inc = clip_inc + LW'(lane_clip[l]);
    end
  end

  // One extra bit catches the carry so the counters stick at all-ones.
  assign neg_sum  = {1'b0, neg_count}  + (CNT_WIDTH + 1)'(neg_inc);
  assign clip_sum = {1'b0, clip_count} + (CNT_WIDTH + 1)'(clip_inc);

  // ------------------------------------------------- control datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_RELU;
      c          <= '0;
      r          <= '0;
      q          <= '0;
      pipe_valid <= 1'b0;
      neg_count  <= '0;
      clip_count <= '0;
    end else begin
      pipe_valid <= (state == ST_RUN);
      if (accept) begin
        mode_q     <= act_mode_t'(mode);
        c          <= '0;
        r          <= '0;
        q          <= '0;
        neg_count  <= '0;
        clip_count <= '0;
      end else begin
        if (state == ST_RUN) begin
          if (q == Q_LAST) begin
            q <= '0;
            if (r == R_LAST) begin
              r <= '0;
              c <= (c == C_LAST) ? '0 : c + 1'b1;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            q <= q + Q_STEP;
          end
        end
        if (pipe_valid) begin
          neg_count  <= neg_sum[CNT_WIDTH]  ? '1 : neg_sum[CNT_WIDTH-1:0];
          clip_count <= clip_sum[CNT_WIDTH] ? '1 : clip_sum[CNT_WIDTH-1:0];
        end
      end
    end
  end

  // ------------------------------------------ read and write stages
  // Storage only: pipe_valid (reset) qualifies every write.
  always_ff @(posedge clk) begin
    if (state == ST_RUN) begin
      pipe_c <= c;
      pipe_r <= r;
      pipe_q <= q;
      for (int l = 0; l < LANES; l++) begin
        pipe_data[l] <= in_feature[c][r][q + QW'(l)];
      end
    end
    if (pipe_valid) begin
      for (int l = 0; l < LANES; l++) begin
        out_feature[pipe_c][pipe_r][pipe_q + QW'(l)] <= lane_y[l];
      end
    end
  end

endmodule
`default_nettype wire
